load_register: RTL and testbench
================================

// Module: load_register
//
// PURPOSE
//   N-bit parallel-load storage register with hold and synchronous clear.
//   Captures data_in on a rising clk edge when load is asserted, otherwise
//   holds its value. Generic pipeline/holding element for datapaths
//   (operand latches, accumulators, staging registers).
//
// PARAMETERS
//   N          8      data width in bits (legal: N >= 1)
//   RST_VALUE  {N{1'b0}}  value loaded by reset (default all zeros)
//
// PORTS
//   clk       input   1  single clock; all state changes on rising edge
//   rst       input   1  reset, synchronous, active-high
//   load      input   1  load enable, active-high
//   data_in   input   N  parallel data to capture
//   data_out  output  N  registered contents (direct flop outputs)
//
// BEHAVIOUR
//   - One clock domain (clk); reset is synchronous and active-high.
//   - Evaluated only at posedge clk, in priority order:
//       1. rst=1            -> data_out <= RST_VALUE (0x00 for N=8)
//       2. rst=0, load=1    -> data_out <= data_in
//       3. rst=0, load=0    -> data_out holds previous value
//   - rst has priority over load: rst=1 with load=1 clears, data_in ignored.
//   - Latency: data_in captured at edge k is visible on data_out after
//     edge k (same cycle, before next edge); one-cycle load-to-output.
//   - data_out is purely registered: no combinational path from any
//     input to data_out; changes only at posedge clk.
//   - Reset value of data_out: RST_VALUE. Before the first reset or load,
//     contents are undefined; no power-up initialisation is required.
//   - rst asserted mid-operation (any cycle) clears on that edge; the
//     following cycle resumes normal load/hold behaviour with rst=0.
//   - No asynchronous behaviour; rst or load pulses between edges have
//     no effect.
//   - Full width captured every load; no partial/byte enables, no
//     truncation or extension.
//
// TESTING
//   Drive inputs at negedge clk, check data_out at the following negedge.
//   - Load: rst=0 load=1 data_in=0x55 -> data_out=0x55 after one edge.
//   - Reload: rst=0 load=1 data_in=0xAA -> data_out=0xAA (overwrites 0x55).
//   - Hold: rst=0 load=0 data_in=0xFF -> data_out stays 0xAA; repeat
//     several cycles with changing data_in, value must not change.
//   - Reset priority: rst=1 load=1 data_in=0xFF -> data_out=0x00.
//   - Sync reset: pulse rst=1 between edges only (low at posedge) ->
//     data_out unchanged; after rst released, load=1 data_in=0x3C -> 0x3C.
//   - Width: N=1 and N=32 instances, load all-ones then all-zeros ->
//     data_out matches full width exactly.

Source files
------------

// File: rtl/load_register.sv
// load_register
//   N-bit parallel-load storage register with hold and synchronous clear.
//   A generic holding element for datapaths: operand latches, accumulators
//   and staging registers.
//
// Parameters
//   N          data width in bits (N >= 1)
//   RST_VALUE  contents after reset
//
// Ports
//   clk       in   1  clock; every state change happens on the rising edge
//   rst       in   1  synchronous active-high reset; takes priority over load
//   load      in   1  active-high load enable
//   data_in   in   N  parallel data, captured when load is high
//   data_out  out  N  registered contents, driven directly by flops
module load_register #(
  parameter int unsigned    N         = 8,
  parameter logic [N-1:0]   RST_VALUE = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] data_in,
  output logic [N-1:0] data_out
);

  logic [N-1:0] data_q;
  logic [N-1:0] data_d;

  // Next state: the full word is taken on load, otherwise it recirculates.
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = data_in;
    end
  end

  // Reset is checked first, so a simultaneous load is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= RST_VALUE;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_out = data_q;

endmodule

// File: tb/tb_load_register.sv
module tb_load_register;

  logic        clk;
  logic        rst;
  logic        load;
  logic [7:0]  data_in8;
  logic [7:0]  data_out8;
  logic [0:0]  data_in1;
  logic [0:0]  data_out1;
  logic [31:0] data_in32;
  logic [31:0] data_out32;

  int n_checks;
  int n_fail;

  load_register #(.N(8)) dut8 (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .data_in  (data_in8),
    .data_out (data_out8)
  );

  load_register #(.N(1)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .data_in  (data_in1),
    .data_out (data_out1)
  );

  load_register #(.N(32)) dut32 (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .data_in  (data_in32),
    .data_out (data_out32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; load = 1'b0;
    data_in8 = 8'h5A; data_in1 = 1'b1; data_in32 = 32'hDEAD_BEEF;
    @(negedge clk);
    n_checks++;
    if (data_out8 !== 8'h00) begin
      n_fail++; $display("FAIL reset8 got=%h exp=%h", data_out8, 8'h00);
    end
    n_checks++;
    if (data_out1 !== 1'b0) begin
      n_fail++; $display("FAIL reset1 got=%h exp=%h", data_out1, 1'b0);
    end
    n_checks++;
    if (data_out32 !== 32'h0) begin
      n_fail++; $display("FAIL reset32 got=%h exp=%h", data_out32, 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (data_out8 !== 8'h00) begin
      n_fail++; $display("FAIL reset_hold got=%h exp=%h", data_out8, 8'h00);
    end
  endtask

  task automatic test_load();
    rst = 1'b0; load = 1'b1; data_in8 = 8'h55;
    @(negedge clk);
    n_checks++;
    if (data_out8 !== 8'h55) begin
      n_fail++; $display("FAIL load got=%h exp=%h", data_out8, 8'h55);
    end
  endtask

  task automatic test_reload();
    rst = 1'b0; load = 1'b1; data_in8 = 8'hAA;
    @(negedge clk);
    n_checks++;
    if (data_out8 !== 8'hAA) begin
      n_fail++; $display("FAIL reload got=%h exp=%h", data_out8, 8'hAA);
    end
  endtask

  task automatic test_hold();
    logic [7:0] vec [4];
    vec[0] = 8'hFF; vec[1] = 8'h00; vec[2] = 8'h3C; vec[3] = 8'hC3;
    rst = 1'b0; load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_in8 = vec[i];
      @(negedge clk);
      n_checks++;
      if (data_out8 !== 8'hAA) begin
        n_fail++; $display("FAIL hold[%0d] got=%h exp=%h", i, data_out8, 8'hAA);
      end
    end
  endtask

  task automatic test_reset_priority();
    rst = 1'b1; load = 1'b1; data_in8 = 8'hFF;
    @(negedge clk);
    n_checks++;
    if (data_out8 !== 8'h00) begin
      n_fail++; $display("FAIL reset_priority got=%h exp=%h", data_out8, 8'h00);
    end
    rst = 1'b0;
  endtask

  task automatic test_sync_reset();
    rst = 1'b0; load = 1'b1; data_in8 = 8'h96;
    @(negedge clk);
    n_checks++;
    if (data_out8 !== 8'h96) begin
      n_fail++; $display("FAIL sync_pre got=%h exp=%h", data_out8, 8'h96);
    end
    // rst pulses high entirely between edges and is low at the posedge.
    load = 1'b0;
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (data_out8 !== 8'h96) begin
      n_fail++; $display("FAIL sync_glitch got=%h exp=%h", data_out8, 8'h96);
    end
    // Reset applied mid-operation clears on that edge, then loads resume.
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (data_out8 !== 8'h00) begin
      n_fail++; $display("FAIL sync_clear got=%h exp=%h", data_out8, 8'h00);
    end
    rst = 1'b0; load = 1'b1; data_in8 = 8'h3C;
    @(negedge clk);
    n_checks++;
    if (data_out8 !== 8'h3C) begin
      n_fail++; $display("FAIL sync_resume got=%h exp=%h", data_out8, 8'h3C);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vec [5];
    vec[0] = 8'h01; vec[1] = 8'h80; vec[2] = 8'h7E; vec[3] = 8'hA5; vec[4] = 8'h5A;
    rst = 1'b0; load = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_in8 = vec[i];
      @(negedge clk);
      n_checks++;
      if (data_out8 !== vec[i]) begin
        n_fail++; $display("FAIL b2b[%0d] got=%h exp=%h", i, data_out8, vec[i]);
      end
    end
  endtask

  task automatic test_width();
    rst = 1'b0; load = 1'b1;
    data_in1 = 1'b1; data_in32 = 32'hFFFF_FFFF; data_in8 = 8'hFF;
    @(negedge clk);
    n_checks++;
    if (data_out1 !== 1'b1) begin
      n_fail++; $display("FAIL width1_ones got=%h exp=%h", data_out1, 1'b1);
    end
    n_checks++;
    if (data_out32 !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL width32_ones got=%h exp=%h", data_out32, 32'hFFFF_FFFF);
    end
    data_in1 = 1'b0; data_in32 = 32'h0000_0000;
    @(negedge clk);
    n_checks++;
    if (data_out1 !== 1'b0) begin
      n_fail++; $display("FAIL width1_zeros got=%h exp=%h", data_out1, 1'b0);
    end
    n_checks++;
    if (data_out32 !== 32'h0000_0000) begin
      n_fail++; $display("FAIL width32_zeros got=%h exp=%h", data_out32, 32'h0);
    end
    data_in32 = 32'h8000_0001;
    @(negedge clk);
    n_checks++;
    if (data_out32 !== 32'h8000_0001) begin
      n_fail++; $display("FAIL width32_edges got=%h exp=%h", data_out32, 32'h8000_0001);
    end
    load = 1'b0; data_in32 = 32'h1234_5678; data_in1 = 1'b1;
    @(negedge clk);
    n_checks++;
    if (data_out32 !== 32'h8000_0001) begin
      n_fail++; $display("FAIL width32_hold got=%h exp=%h", data_out32, 32'h8000_0001);
    end
    n_checks++;
    if (data_out1 !== 1'b0) begin
      n_fail++; $display("FAIL width1_hold got=%h exp=%h", data_out1, 1'b0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; load = 1'b0;
    data_in8 = '0; data_in1 = '0; data_in32 = '0;
    test_reset();
    test_load();
    test_reload();
    test_hold();
    test_reset_priority();
    test_sync_reset();
    test_back_to_back();
    test_width();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
